// File: rtl/sram_ctl.sv
// rtl/sram_ctl.sv - FSM-sequenced async SRAM controller with parametrised wait states and byte lanes.
// Optional SRAM_CTL_BACK2BACK_EN lets a new access start in the final read cycle or the write hold cycle.
module sram_ctl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int RD_WAIT    = 1,
  parameter int WR_WAIT    = 1
) (
  input  logic                    clk_core,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic [DATA_WIDTH-1:0]   sram_d_out,
  output logic                    sram_d_oe,
  input  logic [DATA_WIDTH-1:0]   sram_d_in,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [DATA_WIDTH/8-1:0] sram_be_n
);
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  doe_q, doe_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic [LANES-1:0]      be_n_q, be_n_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  accept;

`ifdef SRAM_CTL_BACK2BACK_EN
  assign req_ready = !reset && ((state_q == IDLE) || (state_q == WR_HOLD) ||
                                ((state_q == RD) && (cnt_q == 4'd0)));
`else
  assign req_ready = !reset && (state_q == IDLE);
`endif

  assign accept = req_valid && req_ready;

  // Every pin value is computed one cycle ahead and registered, so the
  // strobes seen during a state are those set on entry to it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    dout_d      = dout_q;
    doe_d       = 1'b0;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    be_n_d      = '1;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      RD: begin
        if (cnt_q == 4'd0) begin
          rdata_d     = sram_d_in;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          ce_n_d = 1'b0;
          oe_n_d = 1'b0;
          be_n_d = '0;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = 4'(WR_WAIT);
        ce_n_d  = 1'b0;
        be_n_d  = be_n_q;
        we_n_d  = 1'b0;
        doe_d   = 1'b1;
      end
      WR_PULSE: begin
        ce_n_d = 1'b0;
        be_n_d = be_n_q;
        doe_d  = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          we_n_d = 1'b0;
        end
      end
      WR_HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // req_ready is only high in states where starting a new access is legal.
    if (accept) begin
      a_d    = req_addr;
      ce_n_d = 1'b0;
      doe_d  = 1'b0;
      we_n_d = 1'b1;
      if (req_we) begin
        state_d = WR_SETUP;
        dout_d  = req_wdata;
        be_n_d  = ~req_be;
        oe_n_d  = 1'b1;
      end else begin
        state_d = RD;
        cnt_d   = 4'(RD_WAIT);
        oe_n_d  = 1'b0;
        be_n_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      a_q         <= '0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= '1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign sram_a     = a_q;
  assign sram_d_out = dout_q;
  assign sram_d_oe  = doe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_be_n  = be_n_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
endmodule

// File: tb/tb_sram_ctl.sv
// tb/tb_sram_ctl.sv - directed self-checking bench for sram_ctl with a behavioural async SRAM.
module tb_sram_ctl;
`ifdef SRAM_CTL_BACK2BACK_EN
  localparam int RDW = 0;
`else
  localparam int RDW = 1;
`endif

  logic        clk_core = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_be;
  logic [12:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [12:0] sram_a;
  logic [15:0] sram_d_out, sram_d_in;
  logic        sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0]  sram_be_n;

  int checks = 0;
  int failures = 0;
  int n_we_low = 0, n_oe_low = 0, n_doe = 0, n_conflict = 0, n_rsp = 0;
  int s_we, s_oe, s_doe, s_conf, s_rsp;

  sram_ctl #(.ADDR_WIDTH(13), .DATA_WIDTH(16), .RD_WAIT(RDW), .WR_WAIT(1)) dut (
    .clk_core(clk_core), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_a(sram_a), .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe), .sram_d_in(sram_d_in),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk_core = ~clk_core;

  // Async SRAM model: unwritten words read back as their own address.
  logic [15:0] mem [0:8191];
  bit          written [0:8191];
  logic [15:0] wtmp;
  logic [15:0] rd_word;

  assign rd_word   = written[sram_a] ? mem[sram_a] : {3'b000, sram_a};
  assign sram_d_in = (!sram_ce_n && !sram_oe_n) ? rd_word : 16'hDEAD;

  always @(posedge sram_we_n) begin
    if (!sram_ce_n && (sram_be_n != 2'b11)) begin
      wtmp = rd_word;
      for (int i = 0; i < 2; i++)
        if (!sram_be_n[i]) wtmp[8*i +: 8] = sram_d_out[8*i +: 8];
      mem[sram_a]     = wtmp;
      written[sram_a] = 1'b1;
    end
  end

  always @(negedge clk_core) begin
    if (!sram_we_n) n_we_low++;
    if (!sram_oe_n) n_oe_low++;
    if (sram_d_oe) n_doe++;
    if (!sram_oe_n && sram_d_oe) n_conflict++;
    if (rsp_valid) n_rsp++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_we = n_we_low; s_oe = n_oe_low; s_doe = n_doe; s_conf = n_conflict; s_rsp = n_rsp;
  endtask

  // Drives one request and returns 1 time unit after the accepting edge.
  task automatic issue(input logic we, input logic [12:0] a, input logic [15:0] d, input logic [1:0] be);
    @(posedge clk_core); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk_core); #1;
    req_valid = 1'b0;
  endtask

  task automatic rd_check(input logic [12:0] a, input logic [15:0] exp);
    issue(1'b0, a, 16'h0000, 2'b00);
    repeat (RDW + 1) @(posedge clk_core);
    #1;
    chk("rd_valid", rsp_valid, 1'b1);
    chk("rd_data", rsp_rdata, exp);
  endtask

  logic [12:0] hv_a  [3];
  logic        hv_we [3];
  logic [15:0] hv_d  [3];

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_be = 2'b00;
    req_addr = '0; req_wdata = '0;
    #1;
    chk("rst_ce_n", sram_ce_n, 1'b1);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_oe_n", sram_oe_n, 1'b1);
    chk("rst_d_oe", sram_d_oe, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_rdata", rsp_rdata, 16'h0000);
    repeat (3) @(posedge clk_core);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk_core);
    #1;
    chk("idle_ce_n", sram_ce_n, 1'b1);
    chk("idle_oe_n", sram_oe_n, 1'b1);
    chk("idle_we_n", sram_we_n, 1'b1);
    chk("idle_be_n", sram_be_n, 2'b11);
    chk("idle_d_oe", sram_d_oe, 1'b0);
    chk("idle_ready", req_ready, 1'b1);
    chk("idle_rsp", rsp_valid, 1'b0);
    chk("idle_a", sram_a, 13'h0000);

`ifdef SRAM_CTL_BACK2BACK_EN
    snap();
    @(posedge clk_core); #1;
    req_valid = 1'b1; req_we = 1'b0; req_be = 2'b00; req_addr = 13'd0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_core); #1;
      chk("b2b_a", sram_a, k);
      chk("b2b_ce_n", sram_ce_n, 1'b0);
      chk("b2b_ready", req_ready, 1'b1);
      chk("b2b_rsp", rsp_valid, (k > 0) ? 1'b1 : 1'b0);
      if (k > 0) chk("b2b_data", rsp_rdata, k - 1);
      req_addr = 13'(k + 1);
      if (k == 3) req_valid = 1'b0;
    end
    @(posedge clk_core); #1;
    chk("b2b_last_rsp", rsp_valid, 1'b1);
    chk("b2b_last_data", rsp_rdata, 16'h0003);
    chk("b2b_ce_off", sram_ce_n, 1'b1);
    @(posedge clk_core); #1;
    chk("b2b_rsp_end", rsp_valid, 1'b0);
    @(negedge clk_core); #1;
    chk("b2b_rsp_count", n_rsp - s_rsp, 4);
    chk("b2b_conflict", n_conflict - s_conf, 0);
`else
    // Full-word write, then read back.
    snap();
    issue(1'b1, 13'h0123, 16'hA5C3, 2'b11);
    chk("wr_setup_ce_n", sram_ce_n, 1'b0);
    chk("wr_setup_we_n", sram_we_n, 1'b1);
    chk("wr_setup_d_oe", sram_d_oe, 1'b0);
    chk("wr_setup_a", sram_a, 13'h0123);
    chk("wr_setup_dout", sram_d_out, 16'hA5C3);
    chk("wr_setup_be_n", sram_be_n, 2'b00);
    chk("wr_busy_ready", req_ready, 1'b0);
    @(posedge clk_core); #1;
    chk("wr_pulse_we_n", sram_we_n, 1'b0);
    chk("wr_pulse_d_oe", sram_d_oe, 1'b1);
    repeat (3) @(posedge clk_core);
    @(negedge clk_core); #1;
    chk("wr_we_low_cycles", n_we_low - s_we, 2);
    chk("wr_d_oe_cycles", n_doe - s_doe, 3);
    chk("wr_done_ready", req_ready, 1'b1);

    snap();
    issue(1'b0, 13'h0123, 16'h0000, 2'b01);
    chk("rd_oe_n", sram_oe_n, 1'b0);
    chk("rd_be_n", sram_be_n, 2'b00);
    chk("rd_d_oe", sram_d_oe, 1'b0);
    chk("rd_rsp_e0", rsp_valid, 1'b0);
    @(posedge clk_core); #1;
    chk("rd_rsp_e1", rsp_valid, 1'b0);
    @(posedge clk_core); #1;
    chk("rd_rsp_e2", rsp_valid, 1'b1);
    chk("rd_data_a5c3", rsp_rdata, 16'hA5C3);
    chk("rd_end_oe_n", sram_oe_n, 1'b1);
    @(posedge clk_core); #1;
    chk("rd_rsp_e3", rsp_valid, 1'b0);
    chk("rd_data_hold", rsp_rdata, 16'hA5C3);
    @(negedge clk_core); #1;
    chk("rd_oe_low_cycles", n_oe_low - s_oe, 2);
    chk("rd_rsp_count", n_rsp - s_rsp, 1);

    // Lane-0-only write, zero-enable write, and top-of-range address.
    issue(1'b1, 13'h0123, 16'hFF11, 2'b01);
    chk("bytewr_be_n", sram_be_n, 2'b10);
    repeat (4) @(posedge clk_core);
    rd_check(13'h0123, 16'hA511);
    issue(1'b1, 13'h0123, 16'h0000, 2'b00);
    chk("be0_be_n", sram_be_n, 2'b11);
    repeat (4) @(posedge clk_core);
    rd_check(13'h0123, 16'hA511);
    issue(1'b1, 13'h1FFF, 16'h1234, 2'b10);
    repeat (4) @(posedge clk_core);
    rd_check(13'h1FFF, 16'h12FF);

    // req_valid held high across read, write, read.
    hv_a[0] = 13'h0123; hv_we[0] = 1'b0; hv_d[0] = 16'h0000;
    hv_a[1] = 13'h0040; hv_we[1] = 1'b1; hv_d[1] = 16'hBEEF;
    hv_a[2] = 13'h0040; hv_we[2] = 1'b0; hv_d[2] = 16'h0000;
    snap();
    @(posedge clk_core); #1;
    req_valid = 1'b1; req_be = 2'b11;
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 20; t++) begin
        @(negedge clk_core);
        if (req_ready) break;
      end
      chk("hv_ready", req_ready, 1'b1);
      chk("hv_gap_ce_n", sram_ce_n, 1'b1);
      req_we = hv_we[k]; req_addr = hv_a[k]; req_wdata = hv_d[k];
      @(posedge clk_core);
    end
    #1 req_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk_core);
      if (rsp_valid) break;
    end
    chk("hv_rsp", rsp_valid, 1'b1);
    chk("hv_data", rsp_rdata, 16'hBEEF);
    chk("hv_conflict", n_conflict - s_conf, 0);
    chk("hv_rsp_count", n_rsp - s_rsp + 0, 2);

    // Reset asserted during the write pulse.
    issue(1'b1, 13'h0300, 16'h5555, 2'b11);
    @(posedge clk_core); #1;
    chk("ab_pulse_we_n", sram_we_n, 1'b0);
    chk("ab_pulse_d_oe", sram_d_oe, 1'b1);
    snap();
    #1 reset = 1'b1;
    #1;
    chk("ab_we_n", sram_we_n, 1'b1);
    chk("ab_ce_n", sram_ce_n, 1'b1);
    chk("ab_d_oe", sram_d_oe, 1'b0);
    chk("ab_ready", req_ready, 1'b0);
    repeat (2) @(posedge clk_core);
    #1 reset = 1'b0;
    @(posedge clk_core); #1;
    chk("ab_ready_after", req_ready, 1'b1);
    chk("ab_ce_after", sram_ce_n, 1'b1);
    repeat (3) @(posedge clk_core);
    @(negedge clk_core); #1;
    chk("ab_no_rsp", n_rsp - s_rsp, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_ctl.md
Name: sram_ctl

Overview:
Single-clock asynchronous-SRAM controller. It replaces the ad-hoc quadrature-clock write strobe with a state-machine-sequenced access that has parametrised address/data width and wait states, plus per-byte enables. It sits between the SoC memory master and the pad-level bidirectional data I/O cells in the top level. Tristate pads stay outside the block; this block supplies `sram_d_out` and `sram_d_oe`.

Parameters:
- ADDR_WIDTH, 13, SRAM word-address bits.
- DATA_WIDTH, 16, data bits; must be a multiple of 8; LANES = DATA_WIDTH/8.
- RD_WAIT, 1, extra cycles (beyond one) that read strobes are held before the data sample; range 0..15.
- WR_WAIT, 1, extra cycles (beyond one) that we_n is held low; range 0..15.

Ports:
- clk_core  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  master request.
- req_ready  out  1  controller can accept; transfer occurs when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  LANES  byte enables (bit i = byte i).
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid.
- rsp_rdata  out  DATA_WIDTH  registered read data.
- sram_a  out  ADDR_WIDTH  registered address.
- sram_d_out  out  DATA_WIDTH  registered write data to the pads.
- sram_d_oe  out  1  pad output enable.
- sram_d_in  in  DATA_WIDTH  data from the pads.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes.
- sram_be_n  out  LANES  active-low byte lane enables (lane 0 = lb_n, lane 1 = ub_n).

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - ce_n = oe_n = we_n = 1; be_n all 1s.
  - sram_d_oe = 0; rsp_valid = 0.
  - sram_a, sram_d_out, rsp_rdata = 0.
  - req_ready is forced 0 while reset is high.
- Reset mid-access aborts the access with no response. A partially written word is acceptable.
- All SRAM outputs are registered; no combinational path from req_* to the pins.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. A wait counter of 4 bits is sufficient.
- IDLE:
  - req_ready = 1; all strobes inactive; sram_a holds its last value.
  - Accept of a read: latch addr; state goes to RD with cnt = RD_WAIT.
  - Accept of a write: latch addr, wdata and be; state goes to WR_SETUP.
- RD:
  - ce_n = 0, oe_n = 0, all be_n = 0 (reads ignore req_be), sram_d_oe = 0.
  - Each edge: if cnt == 0, capture sram_d_in into rsp_rdata, set rsp_valid = 1 for one cycle, and return to IDLE; otherwise decrement cnt.
  - Strobes are active for exactly RD_WAIT+1 cycles.
  - rsp_valid rises on edge E+RD_WAIT+1, where E is the accepting edge.
- WR_SETUP (1 cycle):
  - ce_n = 0, be_n = ~be, oe_n = 1, we_n = 1, sram_d_oe = 0 (bus-turnaround cycle).
  - Next state: WR_PULSE with cnt = WR_WAIT.
- WR_PULSE:
  - As WR_SETUP, but we_n = 0 and sram_d_oe = 1.
  - Lasts WR_WAIT+1 cycles, then WR_HOLD.
- WR_HOLD (1 cycle):
  - we_n = 1; ce_n, be_n, address, sram_d_oe = 1 and data unchanged.
  - Next state: IDLE.
- Writes produce no response. Write total: WR_WAIT+3 busy cycles.
- be = 0 on a write: the full cycle still runs with all be_n = 1, so memory is unchanged.
- sram_d_oe = 1 only in WR_PULSE/WR_HOLD. oe_n = 0 only in RD. The two are never active together.
- rsp_rdata holds its value until the next read completes.

Optional Feature:
Macro: SRAM_CTL_BACK2BACK_EN.
- Defined:
  - req_ready is also 1 in the final RD cycle (cnt == 0) and in WR_HOLD.
  - An accept there moves directly to RD or WR_SETUP with no IDLE gap; strobes stay low across the boundary.
  - A completing read's rsp_valid still pulses on that edge.
  - Read-to-write turnaround remains safe because WR_SETUP keeps sram_d_oe = 0.
- Undefined: req_ready = 1 only in IDLE, giving at least one idle cycle between accesses.

Test Plan:
- Reset release, then idle 5 cycles -> ce_n/oe_n/we_n = 1, be_n = 2'b11, sram_d_oe = 0, req_ready = 1, rsp_valid = 0.
- RD_WAIT = 1: write 0xA5C3 @0x0123 with be = 2'b11, then read @0x0123 (bench SRAM model):
  - Write: we_n low for exactly 2 cycles, sram_d_oe high for 3 cycles.
  - Read: oe_n low for 2 cycles; rsp_valid one cycle; rsp_rdata = 0xA5C3 two edges after accept.
- Byte-lane write 0xFF11 @0x0123 with be = 2'b01 -> be_n = 2'b10 during the write; a subsequent read returns 0xA511.
- Assert reset during WR_PULSE -> we_n, ce_n = 1 and sram_d_oe = 0 in the same cycle without waiting for a clock edge; no rsp_valid; req_ready = 1 one edge after reset release.
- req_valid held high for read, write, read without the macro -> an IDLE cycle (ce_n = 1) between each access; oe_n and sram_d_oe never both active.
- With SRAM_CTL_BACK2BACK_EN, RD_WAIT = 0, four consecutive reads @0..3 -> one rsp_valid per cycle for 4 cycles, ce_n held low throughout, sram_a = 0, 1, 2, 3 on consecutive cycles.
